// File: rtl/asc_scan_chain_driver.sv
// Scan-chain driver: buffers one ASC packet, shifts it MSB-first into the analog scan chain
// on a divided clock, strobes scan_update, then returns a single ACK byte.
module asc_scan_chain_driver #(
    parameter int          PACKET_BYTES = 22,
    parameter int          SCAN_BITS    = 176,
    parameter int          CLK_DIV      = 8,
    parameter logic [7:0]  ACK_BYTE     = 8'h01
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       asc_data_valid,
    output logic       asc_data_ready,
    input  logic [7:0] asc_data_in,
    output logic       asc_response_valid,
    input  logic       asc_response_ready,
    output logic [7:0] asc_response_data,
    output logic       scan_clk,
    output logic       scan_en,
    output logic       scan_data_out,
    output logic       scan_update,
    output logic       busy
);

    localparam int BYTE_W = $clog2(PACKET_BYTES + 1);
    localparam int BIT_W  = $clog2(SCAN_BITS + 1);
    localparam int ADDR_W = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;

    localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(PACKET_BYTES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SCAN_BITS - 1);

    generate
        if (SCAN_BITS < 1 || SCAN_BITS > PACKET_BYTES * 8) begin : g_bad_scan_bits
            $error("SCAN_BITS must be in 1..PACKET_BYTES*8");
        end
        if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
            $error("CLK_DIV must be in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SHIFT,
        ST_UPDATE,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]        div_cnt_q, div_cnt_d;
    logic              phase_q, phase_d;

    logic [7:0] pkt_mem [PACKET_BYTES];
    logic       in_fire;
    logic [7:0] rd_byte;
    logic [2:0] bit_sel;

    assign in_fire = asc_data_ready && asc_data_valid;

    // Packet buffer holds no reset: byte_cnt restarting at 0 is what discards stale contents.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            pkt_mem[ADDR_W'(byte_cnt_q)] <= asc_data_in;
        end
    end

    assign rd_byte = pkt_mem[ADDR_W'(bit_cnt_q >> 3)];
    assign bit_sel = 3'(bit_cnt_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_LOAD;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            phase_q    <= phase_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        phase_d    = phase_q;
        case (state_q)
            ST_LOAD: begin
                if (in_fire) begin
                    byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                    if (byte_cnt_q == BYTE_LAST) begin
                        state_d   = ST_SHIFT;
                        bit_cnt_d = '0;
                        div_cnt_d = '0;
                        phase_d   = 1'b0;
                    end
                end
            end
            ST_SHIFT: begin
                // phase_q=0 is the low half of a bit window, phase_q=1 the high half.
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    phase_d   = ~phase_q;
                    if (phase_q) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d   = ST_UPDATE;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            ST_UPDATE: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    state_d   = ST_RESP;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (asc_response_ready) begin
                    state_d    = ST_LOAD;
                    byte_cnt_d = '0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Ready is gated by reset_n so nothing is offered while reset is held.
    assign asc_data_ready     = reset_n && (state_q == ST_LOAD);
    assign busy               = (state_q != ST_LOAD);
    assign scan_en            = (state_q == ST_SHIFT);
    assign scan_clk           = scan_en && phase_q;
    assign scan_data_out      = scan_en && rd_byte[~bit_sel];
    assign scan_update        = (state_q == ST_UPDATE);
    assign asc_response_valid = (state_q == ST_RESP);
    assign asc_response_data  = asc_response_valid ? ACK_BYTE : 8'h00;

endmodule

// File: tb/tb_asc_scan_chain_driver.sv
// Directed/randomized bench for asc_scan_chain_driver: default instance plus a small
// (CLK_DIV=1, SCAN_BITS=12, PACKET_BYTES=2) instance, checked against a bit-stream model.
module tb_asc_scan_chain_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n    = 1'b0;
    logic       sel      = 1'b0;
    logic       valid_tb = 1'b0;
    logic [7:0] data_tb  = 8'h00;
    logic       rready_tb = 1'b0;

    logic       a_rdy, a_rvalid, a_clk, a_en, a_dout, a_upd, a_busy;
    logic [7:0] a_rdata;
    logic       b_rdy, b_rvalid, b_clk, b_en, b_dout, b_upd, b_busy;
    logic [7:0] b_rdata;

    asc_scan_chain_driver dut (
        .clk(clk), .reset_n(rst_n),
        .asc_data_valid(valid_tb & ~sel), .asc_data_ready(a_rdy), .asc_data_in(data_tb),
        .asc_response_valid(a_rvalid), .asc_response_ready(rready_tb & ~sel),
        .asc_response_data(a_rdata),
        .scan_clk(a_clk), .scan_en(a_en), .scan_data_out(a_dout), .scan_update(a_upd),
        .busy(a_busy)
    );

    asc_scan_chain_driver #(.PACKET_BYTES(2), .SCAN_BITS(12), .CLK_DIV(1), .ACK_BYTE(8'h01)) dut_small (
        .clk(clk), .reset_n(rst_n),
        .asc_data_valid(valid_tb & sel), .asc_data_ready(b_rdy), .asc_data_in(data_tb),
        .asc_response_valid(b_rvalid), .asc_response_ready(rready_tb & sel),
        .asc_response_data(b_rdata),
        .scan_clk(b_clk), .scan_en(b_en), .scan_data_out(b_dout), .scan_update(b_upd),
        .busy(b_busy)
    );

    logic       obs_rdy, obs_rvalid, obs_clk, obs_en, obs_dout, obs_upd, obs_busy;
    logic [7:0] obs_rdata;
    always_comb begin
        obs_rdy    = sel ? b_rdy    : a_rdy;
        obs_rvalid = sel ? b_rvalid : a_rvalid;
        obs_rdata  = sel ? b_rdata  : a_rdata;
        obs_clk    = sel ? b_clk    : a_clk;
        obs_en     = sel ? b_en     : a_en;
        obs_dout   = sel ? b_dout   : a_dout;
        obs_upd    = sel ? b_upd    : a_upd;
        obs_busy   = sel ? b_busy   : a_busy;
    end

    int tests = 0;
    int fails = 0;
    int cur_d  = 8;
    int cur_sb = 176;
    int cur_pb = 22;
    logic [7:0] pkt[$];
    logic       captured[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference stream: bit k is byte k/8, MSB first; nothing past SCAN_BITS.
    function automatic logic exp_bit(input int k);
        if (k < 0 || k >= cur_sb || (k / 8) >= pkt.size()) return 1'b0;
        return pkt[k / 8][7 - (k % 8)];
    endfunction

    task automatic make_pkt(input logic [7:0] first, input bit fixed_first);
        pkt.delete();
        for (int i = 0; i < cur_pb; i++) pkt.push_back(8'($urandom));
        if (fixed_first) pkt[0] = first;
    endtask

    task automatic send_pkt(input string tag, input int maxgap);
        int n;
        for (int i = 0; i < cur_pb; i++) begin
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) step();
            valid_tb = 1'b1;
            data_tb  = pkt[i];
            n = 0;
            while (obs_rdy !== 1'b1 && n < 200) begin
                step();
                n++;
            end
            if (n >= 200) check({tag, "_ready_timeout"}, 32'(n), 32'd0);
            step();
            valid_tb = 1'b0;
        end
        $display("[TB] %s: sent %0d bytes", tag, cur_pb);
    endtask

    task automatic run_shift(input string tag, input int abort_bit);
        int cyc = 0, rises = 0, bad_d = 0, bad_c = 0, bad_o = 0, u = 0, bad_u = 0;
        int period = 2 * cur_d;
        logic prev = 1'b0;
        captured.delete();
        check({tag, "_shift_entry"}, 32'(obs_en), 32'd1);
        while (obs_en === 1'b1 && cyc < 20000) begin
            if (cyc == abort_bit * period) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_scan_en"}, 32'(obs_en), 32'd0);
                check({tag, "_rst_scan_clk"}, 32'(obs_clk), 32'd0);
                check({tag, "_rst_busy"}, 32'(obs_busy), 32'd0);
                step();
                step();
                rst_n = 1'b1;
                #1;
                check({tag, "_rst_release_ready"}, 32'(obs_rdy), 32'd1);
                $display("[TB] %s: reset applied at shift cycle %0d", tag, cyc);
                return;
            end
            if (obs_clk !== ((cyc % period) >= cur_d)) bad_c++;
            if (obs_dout !== exp_bit(cyc / period)) bad_d++;
            if (obs_rdy !== 1'b0 || obs_busy !== 1'b1 || obs_upd !== 1'b0 || obs_rvalid !== 1'b0) bad_o++;
            if (obs_clk === 1'b1 && prev === 1'b0) begin
                rises++;
                captured.push_back(obs_dout);
            end
            prev = obs_clk;
            step();
            cyc++;
        end
        check({tag, "_shift_cycles"}, 32'(cyc), 32'(cur_sb * period));
        check({tag, "_rising_edges"}, 32'(rises), 32'(cur_sb));
        check({tag, "_data_errs"}, 32'(bad_d), 32'd0);
        check({tag, "_clk_errs"}, 32'(bad_c), 32'd0);
        check({tag, "_side_errs"}, 32'(bad_o), 32'd0);
        while (obs_upd === 1'b1 && u < 1000) begin
            if (obs_clk !== 1'b0 || obs_en !== 1'b0 || obs_dout !== 1'b0 || obs_busy !== 1'b1) bad_u++;
            step();
            u++;
        end
        check({tag, "_update_len"}, 32'(u), 32'(cur_d));
        check({tag, "_update_errs"}, 32'(bad_u), 32'd0);
        $display("[TB] %s: shift %0d cycles, %0d edges, update %0d cycles", tag, cyc, rises, u);
    endtask

    task automatic take_ack(input string tag, input int hold);
        int bad = 0;
        check({tag, "_ack_valid"}, 32'(obs_rvalid), 32'd1);
        check({tag, "_ack_data"}, 32'(obs_rdata), 32'h01);
        for (int i = 0; i < hold; i++) begin
            step();
            if (obs_rvalid !== 1'b1 || obs_rdata !== 8'h01 || obs_rdy !== 1'b0 || obs_busy !== 1'b1) bad++;
        end
        if (hold > 0) check({tag, "_ack_hold_errs"}, 32'(bad), 32'd0);
        rready_tb = 1'b1;
        step();
        rready_tb = 1'b0;
        check({tag, "_post_ack_ready"}, 32'(obs_rdy), 32'd1);
        check({tag, "_post_ack_valid"}, 32'(obs_rvalid), 32'd0);
        check({tag, "_post_ack_data"}, 32'(obs_rdata), 32'd0);
        check({tag, "_post_ack_busy"}, 32'(obs_busy), 32'd0);
        $display("[TB] %s: ACK accepted after %0d held cycles", tag, hold);
    endtask

    initial begin
        int extra;
        logic [7:0] first8;

        #3;
        check("reset_ready", 32'(a_rdy), 32'd0);
        check("reset_busy", 32'(a_busy), 32'd0);
        check("reset_scan", {29'd0, a_en, a_clk, a_upd}, 32'd0);
        check("reset_resp", {23'd0, a_rvalid, a_rdata}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("reset_release_ready", 32'(a_rdy), 32'd1);

        // 1: sequential bytes back-to-back
        pkt.delete();
        for (int i = 0; i < cur_pb; i++) pkt.push_back(8'(i));
        send_pkt("t1", 0);
        run_shift("t1", -1);
        take_ack("t1", 0);

        // 2: random gaps, leading 0xA5
        make_pkt(8'hA5, 1'b1);
        send_pkt("t2", 5);
        run_shift("t2", -1);
        first8 = 8'h00;
        if (captured.size() >= 8) for (int i = 0; i < 8; i++) first8 = {first8[6:0], captured[i]};
        check("t2_first8", 32'(first8), 32'hA5);
        take_ack("t2", 0);

        // 3: ACK back-pressure
        make_pkt(8'h00, 1'b0);
        send_pkt("t3", 2);
        run_shift("t3", -1);
        take_ack("t3", 50);

        // 4: valid held high through SHIFT is ignored
        make_pkt(8'h00, 1'b0);
        send_pkt("t4", 0);
        valid_tb = 1'b1;
        data_tb  = 8'hEE;
        run_shift("t4", -1);
        valid_tb = 1'b0;
        take_ack("t4", 3);
        make_pkt(8'h00, 1'b0);
        send_pkt("t4b", 1);
        run_shift("t4b", -1);
        take_ack("t4b", 0);

        // 5: reset at bit 40, then a clean packet ACKs once
        make_pkt(8'h00, 1'b0);
        send_pkt("t5", 0);
        run_shift("t5", 40);
        make_pkt(8'h00, 1'b0);
        send_pkt("t5b", 0);
        run_shift("t5b", -1);
        take_ack("t5b", 0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (obs_rvalid !== 1'b0 || obs_rdy !== 1'b1) extra++;
        end
        check("t5_single_ack", 32'(extra), 32'd0);

        // 6: small instance
        sel    = 1'b1;
        cur_d  = 1;
        cur_sb = 12;
        cur_pb = 2;
        #1;
        check("t6_idle_ready", 32'(obs_rdy), 32'd1);
        make_pkt(8'hC3, 1'b1);
        pkt[1] = 8'h5A;
        send_pkt("t6", 0);
        run_shift("t6", -1);
        take_ack("t6", 0);
        make_pkt(8'h00, 1'b0);
        send_pkt("t6b", 3);
        run_shift("t6b", -1);
        take_ack("t6b", 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
